// File: rtl/ss_pkg.sv
// rtl/ss_pkg.sv - shared types and address map for the save-state initiator
// Contents:
//   ss_state_t      : session FSM state encoding
//   SS_ADDR_IRQ     : mapper save-state address of the IRQ block
//   SS_ADDR_MAPIDX  : mapper save-state address of the mapper index byte
package ss_pkg;

    typedef enum logic [3:0] {
        IDLE,
        S_ADDR,
        S_SETTLE,
        S_STORE,
        L_FETCH,
        L_DATA,
        L_WAIT_HI,
        L_WAIT_LO,
        FIN
    } ss_state_t;

    localparam logic [7:0] SS_ADDR_IRQ    = 8'd16;
    localparam logic [7:0] SS_ADDR_MAPIDX = 8'd127;

endpackage

// File: rtl/ss_master_if.sv
// rtl/ss_master_if.sv - mapper save-state port plus state buffer port
// Signals:
//   ss_act, ss_we, ss_addr, ss_wdat : initiator -> mapper
//   ss_rdat                         : mapper -> initiator, combinational in ss_addr
//   buf_addr, buf_we, buf_wdat      : initiator -> byte buffer
//   buf_rdat                        : buffer -> initiator, valid 1 clk after buf_addr
// Modports: master (ss_master side), slave (mapper/buffer side).
interface ss_master_if;

    logic       ss_act;
    logic       ss_we;
    logic [7:0] ss_addr;
    logic [7:0] ss_wdat;
    logic [7:0] ss_rdat;
    logic [7:0] buf_addr;
    logic       buf_we;
    logic [7:0] buf_wdat;
    logic [7:0] buf_rdat;

    modport master (
        output ss_act, ss_we, ss_addr, ss_wdat, buf_addr, buf_we, buf_wdat,
        input  ss_rdat, buf_rdat
    );

    modport slave (
        input  ss_act, ss_we, ss_addr, ss_wdat, buf_addr, buf_we, buf_wdat,
        output ss_rdat, buf_rdat
    );

endinterface

// File: rtl/ss_master_sync2.sv
// rtl/ss_master_sync2.sv - two-flop synchronizer for a single asynchronous bit
// Ports:
//   clk, rst : destination clock, asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output, two clk of latency
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ss_master.sv
// rtl/ss_master.sv - save-state initiator sweeping mapper state into/out of a byte buffer
// Ports:
//   clk, rst               : system clock, asynchronous active-high reset
//   start_save, start_load : one-cycle session requests (save wins if both)
//   m2                     : CPU M2, asynchronous; mappers latch writes on its falling edge
//   bus                    : mapper save-state port and buffer port (master modport)
//   busy, done, err        : session active, completion pulse, sticky m2 timeout
module ss_master #(
    parameter int SS_LEN     = 128,
    parameter int SETTLE     = 2,
    parameter int M2_TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_save,
    input  logic               start_load,
    input  logic               m2,
    ss_master_if.master        bus,
    output logic               busy,
    output logic               done,
    output logic               err
);

    import ss_pkg::*;

    localparam int         TMAX = (M2_TIMEOUT > SETTLE) ? M2_TIMEOUT : SETTLE;
    localparam int         TW   = $clog2(TMAX + 1);
    localparam logic [7:0] LAST = 8'(SS_LEN - 1);

    generate
        if (SS_LEN < 1 || SS_LEN > 255) begin : g_len_check
            $error("ss_master: SS_LEN must be in 1..255");
        end
        if (M2_TIMEOUT < 2) begin : g_timeout_check
            $error("ss_master: M2_TIMEOUT must be at least 2");
        end
    endgenerate

    ss_state_t     state, state_n;
    logic [7:0]    idx, idx_n;
    logic [TW-1:0] timer, timer_n;
    logic [7:0]    wdat_q, wdat_n;
    logic          err_n;
    logic          m2_s;

    sync2 u_m2_sync (
        .clk (clk),
        .rst (rst),
        .d   (m2),
        .q   (m2_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= 8'd0;
            timer  <= '0;
            wdat_q <= 8'd0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            timer  <= timer_n;
            wdat_q <= wdat_n;
            err    <= err_n;
        end
    end

    // The timer restarts from zero on every state change; it counts settle
    // cycles in S_SETTLE and elapsed cycles in the two m2 wait states.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        timer_n = '0;
        wdat_n  = wdat_q;
        err_n   = err;

        case (state)
            IDLE: begin
                if (start_save) begin
                    err_n   = 1'b0;
                    idx_n   = 8'd0;
                    state_n = S_ADDR;
                end else if (start_load) begin
                    err_n   = 1'b0;
                    idx_n   = 8'd0;
                    state_n = L_FETCH;
                end
            end

            S_ADDR: begin
                state_n = (SETTLE == 0) ? S_STORE : S_SETTLE;
            end

            S_SETTLE: begin
                if (timer == TW'(SETTLE - 1)) begin
                    state_n = S_STORE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end

            S_STORE: begin
                if (idx == LAST) begin
                    state_n = FIN;
                end else begin
                    idx_n   = idx + 8'd1;
                    state_n = S_ADDR;
                end
            end

            L_FETCH: begin
                state_n = L_DATA;
            end

            L_DATA: begin
                wdat_n  = bus.buf_rdat;
                state_n = L_WAIT_HI;
            end

            // The first cycle here still shows m2 as sampled before ss_we
            // rose, so a high level only counts from the second cycle on.
            // That guarantees the falling edge awaited next happens while
            // ss_we is already asserted.
            L_WAIT_HI: begin
                if (m2_s && timer != '0) begin
                    state_n = L_WAIT_LO;
                end else if (timer == TW'(M2_TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = FIN;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end

            L_WAIT_LO: begin
                if (!m2_s) begin
                    if (idx == LAST) begin
                        state_n = FIN;
                    end else begin
                        idx_n   = idx + 8'd1;
                        state_n = L_FETCH;
                    end
                end else if (timer == TW'(M2_TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = FIN;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end

            FIN: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs decode from the state register so that an asynchronous reset
    // drops ss_act/ss_we immediately.
    assign busy = (state != IDLE) && (state != FIN);
    assign done = (state == FIN);

    assign bus.ss_act   = busy;
    assign bus.ss_we    = (state == L_DATA) || (state == L_WAIT_HI) || (state == L_WAIT_LO);
    // During L_DATA the buffer byte is passed straight through so data is
    // valid the same cycle ss_we rises; afterwards the latched copy holds it.
    assign bus.ss_wdat  = (state == L_DATA) ? bus.buf_rdat : wdat_q;
    assign bus.ss_addr  = idx;
    assign bus.buf_addr = idx;
    assign bus.buf_we   = (state == S_STORE);
    assign bus.buf_wdat = (state == S_STORE) ? bus.ss_rdat : 8'd0;

endmodule

// File: tb/tb_ss_master.sv
// tb/tb_ss_master.sv - directed bench for ss_master (SS_LEN=128 and SS_LEN=1 instances)
module tb_ss_master;

    import ss_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic m2;
    logic m2_en;
    logic start_save, start_load, start_save1, start_load1;
    logic busy, done, err, busy1, done1, err1;

    ss_master_if bus ();
    ss_master_if bus1 ();

    always #5 clk = ~clk;

    ss_master u_dut (
        .clk        (clk),
        .rst        (rst),
        .start_save (start_save),
        .start_load (start_load),
        .m2         (m2),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    ss_master #(.SS_LEN(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .start_save (start_save1),
        .start_load (start_load1),
        .m2         (m2),
        .bus        (bus1),
        .busy       (busy1),
        .done       (done1),
        .err        (err1)
    );

    // m2 at clk/12 when enabled, otherwise parked low
    initial begin
        m2 = 1'b0;
        forever begin
            repeat (6) @(posedge clk);
            #3;
            m2 = m2_en ? ~m2 : 1'b0;
        end
    end

    // mapper models: readback addr^A5, latch on negedge m2 while ss_we
    assign bus.ss_rdat  = bus.ss_addr ^ 8'hA5;
    assign bus1.ss_rdat = bus1.ss_addr ^ 8'hA5;

    logic [7:0] map_mem  [0:255];
    logic [7:0] map1_mem [0:255];
    int latch_cnt = 0, latch1_cnt = 0, addr_chg = 0, done_cnt = 0, bwe1_cnt = 0;
    logic       prev_we = 1'b0;
    logic [7:0] prev_addr = 8'd0;

    always @(negedge m2) begin
        if (bus.ss_we) begin
            map_mem[bus.ss_addr] <= bus.ss_wdat;
            latch_cnt <= latch_cnt + 1;
        end
        if (bus1.ss_we) begin
            map1_mem[bus1.ss_addr] <= bus1.ss_wdat;
            latch1_cnt <= latch1_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (bus.ss_we && prev_we && bus.ss_addr != prev_addr) addr_chg <= addr_chg + 1;
        prev_we   <= bus.ss_we;
        prev_addr <= bus.ss_addr;
        if (done) done_cnt <= done_cnt + 1;
        if (bus1.buf_we) bwe1_cnt <= bwe1_cnt + 1;
    end

    // buffer models with a bench-side preload port
    logic [7:0] buf_mem  [0:255];
    logic [7:0] buf1_mem [0:255];
    logic       tb_wr, tb_wr1;
    logic [7:0] tb_waddr, tb_wdata;

    always @(posedge clk) begin
        if (bus.buf_we) buf_mem[bus.buf_addr] <= bus.buf_wdat;
        else if (tb_wr) buf_mem[tb_waddr] <= tb_wdata;
        bus.buf_rdat <= buf_mem[bus.buf_addr];
        if (bus1.buf_we) buf1_mem[bus1.buf_addr] <= bus1.buf_wdat;
        else if (tb_wr1) buf1_mem[tb_waddr] <= tb_wdata;
        bus1.buf_rdat <= buf1_mem[bus1.buf_addr];
    end

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int snap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic fill(input bit inst, input int mode);
        for (int k = 0; k < 256; k++) begin
            tb_wr    = ~inst;
            tb_wr1   = inst;
            tb_waddr = 8'(k);
            tb_wdata = (mode == 1) ? 8'(255 - k) : (mode == 2) ? 8'h3C : 8'h00;
            step();
        end
        tb_wr  = 1'b0;
        tb_wr1 = 1'b0;
    endtask

    task automatic wait_done(input bit inst, input int limit, input string tag);
        while (((inst ? done1 : done) == 1'b0) && cyc < limit) step();
        check({tag, "_done"}, inst ? done1 : done, 1);
    endtask

    initial begin
        rst = 1'b1; m2_en = 1'b0;
        start_save = 0; start_load = 0; start_save1 = 0; start_load1 = 0;
        tb_wr = 0; tb_wr1 = 0; tb_waddr = 0; tb_wdata = 0;

        // reset state
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_act", bus.ss_act, 0);
        check("rst_we", bus.ss_we, 0);
        check("rst_addr", bus.ss_addr, 0);
        check("rst_wdat", bus.ss_wdat, 0);
        check("rst_bwe", bus.buf_we, 0);
        check("rst_bwdat", bus.buf_wdat, 0);
        rst = 1'b0;
        fill(0, 0);

        // save sweep: buffer[k] = k^A5, done at 4*128+1
        cyc = 0;
        start_save = 1; step(); start_save = 0;
        check("save_busy_rise", busy, 1);
        check("save_act", bus.ss_act, 1);
        wait_done(0, 2000, "save");
        check("save_lat", cyc, 513);
        check("save_busy_fin", busy, 0);
        check("save_we_fin", bus.ss_we, 0);
        for (int k = 0; k < 128; k++) check("save_buf", buf_mem[k], 32'(k ^ 8'hA5));
        check("save_buf_irq", buf_mem[SS_ADDR_IRQ], 32'(SS_ADDR_IRQ ^ 8'hA5));
        check("save_buf_128", buf_mem[128], 0);
        step();
        check("save_done_pulse", done, 0);

        // simultaneous starts pick save; start_load while busy ignored
        fill(0, 0);
        snap = done_cnt;
        cyc = 0;
        start_save = 1; start_load = 1; step(); start_save = 0; start_load = 0;
        repeat (100) step();
        start_load = 1; step(); start_load = 0;
        check("both_no_we", bus.ss_we, 0);
        wait_done(0, 2000, "both");
        check("both_lat", cyc, 513);
        check("both_buf5", buf_mem[5], 32'(8'd5 ^ 8'hA5));
        repeat (60) step();
        check("both_one_done", done_cnt - snap, 1);
        check("both_idle", busy, 0);

        // load sweep: mapper latches 255-k at each address
        fill(0, 1);
        m2_en = 1'b1;
        snap = latch_cnt;
        cyc = 0;
        start_load = 1; step(); start_load = 0;
        wait_done(0, 20000, "load");
        check("load_err", err, 0);
        check("load_we_fin", bus.ss_we, 0);
        step(); step();
        check("load_latches", latch_cnt - snap, 128);
        check("load_addr_chg", addr_chg, 0);
        for (int k = 0; k < 128; k++) check("load_map", map_mem[k], 32'(255 - k));
        check("load_map_idx", map_mem[SS_ADDR_MAPIDX], 32'(8'd255 - SS_ADDR_MAPIDX));

        // m2 parked low: timeout
        m2_en = 1'b0;
        repeat (10) step();
        snap = latch_cnt;
        cyc = 0;
        start_load = 1; step(); start_load = 0;
        wait_done(0, 6000, "to");
        check("to_lat", (cyc >= 4096 && cyc <= 4100), 1);
        check("to_err", err, 1);
        check("to_we", bus.ss_we, 0);
        check("to_act", bus.ss_act, 0);
        step();
        check("to_err_sticky", err, 1);
        check("to_no_latch", latch_cnt - snap, 0);

        // reset at byte 40 of a load, then a clean save
        m2_en = 1'b1;
        cyc = 0;
        start_load = 1; step(); start_load = 0;
        check("rst40_err_clr", err, 0);
        while (!(bus.ss_addr == 8'd40 && bus.ss_we) && cyc < 20000) step();
        check("rst40_reach", bus.ss_addr, 40);
        snap = done_cnt;
        rst = 1'b1;
        #1;
        check("rst40_act", bus.ss_act, 0);
        check("rst40_we", bus.ss_we, 0);
        check("rst40_busy", busy, 0);
        step(); step();
        rst = 1'b0;
        repeat (20) step();
        check("rst40_no_done", done_cnt - snap, 0);
        m2_en = 1'b0;
        fill(0, 0);
        cyc = 0;
        start_save = 1; step(); start_save = 0;
        wait_done(0, 2000, "resave");
        check("resave_lat", cyc, 513);
        check("resave_buf40", buf_mem[40], 32'(8'd40 ^ 8'hA5));
        check("resave_buf127", buf_mem[127], 32'(8'd127 ^ 8'hA5));

        // SS_LEN=1: single store, single latch
        snap = bwe1_cnt;
        cyc = 0;
        start_save1 = 1; step(); start_save1 = 0;
        wait_done(1, 100, "one_save");
        check("one_save_lat", cyc, 5);
        step();
        check("one_save_bwe", bwe1_cnt - snap, 1);
        check("one_save_buf", buf1_mem[0], 8'hA5);
        fill(1, 2);
        m2_en = 1'b1;
        snap = latch1_cnt;
        cyc = 0;
        start_load1 = 1; step(); start_load1 = 0;
        wait_done(1, 500, "one_load");
        check("one_load_err", err1, 0);
        step(); step();
        check("one_load_latch", latch1_cnt - snap, 1);
        check("one_load_map", map1_mem[0], 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
